// File: rtl/conf_pkg.sv
// Shared definitions for the run sequencer and the config register block:
// sequencer state encoding, STATUS codes and CONFIG_DATA word layout.
package conf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_BADCMD  = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  localparam int WORD_CMD = 0;
  localparam int WORD_SRC = 1;
  localparam int WORD_DST = 2;
  localparam int WORD_LEN = 3;

endpackage

// File: rtl/done_tracker.sv
// Sticky read/write completion flags plus the saturating RUN-cycle counter.
// clear (START) restarts tracking but still captures pulses arriving that cycle.
module done_tracker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        track,
  input  logic        rd_done,
  input  logic        wr_done,
  output logic        both_done,
  output logic [31:0] cycles
);

  logic rd_flag;
  logic wr_flag;

  // Flag capture and cycle counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_flag <= 1'b0;
      wr_flag <= 1'b0;
      cycles  <= 32'd0;
    end else if (clear) begin
      rd_flag <= rd_done;
      wr_flag <= wr_done;
      cycles  <= 32'd0;
    end else if (track) begin
      rd_flag <= rd_flag | rd_done;
      wr_flag <= wr_flag | wr_done;
      if (cycles != 32'hFFFF_FFFF) begin
        cycles <= cycles + 32'd1;
      end
    end
  end

  // Stale flags from the previous command must not count during START
  assign both_done = ((rd_flag && !clear) || rd_done) &&
                     ((wr_flag && !clear) || wr_done);

endmodule

// File: rtl/run_sequencer.sv
// Command sequencer: accepts a config command, flushes the datapath, kicks the
// read and write engines, waits for both to finish (or time out) and reports.
module run_sequencer
  import conf_pkg::*;
#(
  parameter int NREG      = 4,
  parameter int W         = 32,
  parameter int FLUSH_CYC = 4,
  parameter int TIMEOUT   = 1 << 24
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            CONFIG_VALID,
  output logic            CONFIG_READY,
  input  logic [NREG*W-1:0] CONFIG_DATA,
  output logic            RD_START,
  output logic [31:0]     RD_ADDR,
  output logic [31:0]     RD_LEN,
  input  logic            RD_DONE,
  output logic            WR_START,
  output logic [31:0]     WR_ADDR,
  output logic [31:0]     WR_LEN,
  input  logic            WR_DONE,
  output logic            PIPE_RESET,
  output logic [1:0]      STATUS,
  output logic [31:0]     CYCLES
);

  localparam int FCW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

  logic           rst_meta;
  logic           rst_sync;
  seq_state_t     state;
  seq_state_t     state_nxt;
  logic [FCW-1:0] flush_cnt;
  logic [1:0]     status_r;
  logic           cmd_go;
  logic [31:0]    src_w;
  logic [31:0]    dst_w;
  logic [31:0]    len_w;
  logic           bad_cmd;
  logic           accept;
  logic           both_done;
  logic           timeout_hit;

  // Reset synchronizer: assert immediately, release two ACLK edges later
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign cmd_go      = CONFIG_DATA[WORD_CMD*W];
  assign src_w       = 32'(CONFIG_DATA[WORD_SRC*W +: W]);
  assign dst_w       = 32'(CONFIG_DATA[WORD_DST*W +: W]);
  assign len_w       = 32'(CONFIG_DATA[WORD_LEN*W +: W]);
  assign bad_cmd     = !cmd_go || (len_w == 32'd0);
  assign accept      = CONFIG_VALID && (state == ST_IDLE);
  // Counter after this RUN cycle will equal TIMEOUT
  assign timeout_hit = (CYCLES >= 32'(TIMEOUT - 1));

  done_tracker u_done_tracker (
    .clk       (ACLK),
    .rst_n     (rst_sync),
    .clear     (state == ST_START),
    .track     (state == ST_RUN),
    .rd_done   (RD_DONE),
    .wr_done   (WR_DONE),
    .both_done (both_done),
    .cycles    (CYCLES)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (CONFIG_VALID) begin
          state_nxt = bad_cmd ? ST_FIN : ST_FLUSH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FCW'(1)) begin
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_START: begin
        if (both_done) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (both_done || timeout_hit) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, command capture, flush countdown and status
  always_ff @(posedge ACLK or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      status_r  <= STATUS_OK;
      RD_ADDR   <= 32'd0;
      WR_ADDR   <= 32'd0;
      RD_LEN    <= 32'd0;
      WR_LEN    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        RD_ADDR   <= src_w;
        WR_ADDR   <= dst_w;
        RD_LEN    <= len_w;
        WR_LEN    <= len_w;
        status_r  <= bad_cmd ? STATUS_BADCMD : STATUS_OK;
        flush_cnt <= FCW'(FLUSH_CYC);
      end else if (state == ST_FLUSH) begin
        flush_cnt <= flush_cnt - FCW'(1);
      end
      if ((state == ST_RUN) && !both_done && timeout_hit) begin
        status_r <= STATUS_TIMEOUT;
      end
    end
  end

  assign STATUS       = status_r;
  assign CONFIG_READY = (state == ST_IDLE);
  assign RD_START     = (state == ST_START);
  assign WR_START     = (state == ST_START);
  assign PIPE_RESET   = (state == ST_FLUSH) ||
                        ((state == ST_FIN) && (status_r == STATUS_TIMEOUT));

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: expected results are queued when a command
// is driven and compared when the sequencer returns to idle.
module tb_run_sequencer;

  localparam int FLUSH = 4;
  localparam int TMO   = 64;

  logic         ACLK;
  logic         ARESETN;
  logic         CONFIG_VALID;
  logic         CONFIG_READY;
  logic [127:0] CONFIG_DATA;
  logic         RD_START, WR_START, RD_DONE, WR_DONE, PIPE_RESET;
  logic [31:0]  RD_ADDR, RD_LEN, WR_ADDR, WR_LEN, CYCLES;
  logic [1:0]   STATUS;

  run_sequencer #(.NREG(4), .W(32), .FLUSH_CYC(FLUSH), .TIMEOUT(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CONFIG_VALID(CONFIG_VALID),
    .CONFIG_READY(CONFIG_READY), .CONFIG_DATA(CONFIG_DATA),
    .RD_START(RD_START), .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_DONE(RD_DONE),
    .WR_START(WR_START), .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_DONE(WR_DONE),
    .PIPE_RESET(PIPE_RESET), .STATUS(STATUS), .CYCLES(CYCLES)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] cycles;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          lat;
    int          pr;
    int          st;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int pr_cnt   = 0;
  int rds      = 0;
  int wrs      = 0;
  int rel      = -1;
  int idle_cyc = 0;
  logic [31:0] last_cyc = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the next falling edge and record what the DUT did
  task automatic step();
    logic acc;
    int   drv;
    acc = CONFIG_VALID && CONFIG_READY;
    drv = cyc;
    @(negedge ACLK);
    cyc++;
    if (acc === 1'b1) begin
      acc_cyc = drv; pr_cnt = 0; rds = 0; wrs = 0; rel = -1;
    end
    if (PIPE_RESET === 1'b1) pr_cnt++;
    if (WR_START === 1'b1) wrs++;
    if (RD_START === 1'b1) rel = 0;
    else if (rel >= 0) rel++;
    if (RD_START === 1'b1) rds++;
  endtask

  // Expected outcome from command fields and done-pulse offsets (relative to START)
  task automatic push_exp(input logic [31:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input int rd_off, input int wr_off);
    exp_t e;
    int   d;
    e.src = src; e.dst = dst; e.len = len;
    if (cmd[0] == 1'b0 || len == 32'd0) begin
      e.status = 2'b01; e.cycles = last_cyc; e.lat = 2; e.pr = 0; e.st = 0;
    end else begin
      d = (rd_off > wr_off) ? rd_off : wr_off;
      e.st = 1;
      if (rd_off >= 0 && wr_off >= 0 && d <= TMO) begin
        e.status = 2'b00; e.cycles = 32'(d); e.lat = FLUSH + 1 + d + 2; e.pr = FLUSH;
      end else begin
        e.status = 2'b10; e.cycles = 32'(TMO); e.lat = FLUSH + 1 + TMO + 2; e.pr = FLUSH + 1;
      end
    end
    last_cyc = e.cycles;
    sb.push_back(e);
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("ready", {31'd0, CONFIG_READY}, 32'd1);
      chk("status", {30'd0, STATUS}, {30'd0, e.status});
      chk("cycles", CYCLES, e.cycles);
      chk("rd_addr", RD_ADDR, e.src);
      chk("wr_addr", WR_ADDR, e.dst);
      chk("rd_len", RD_LEN, e.len);
      chk("wr_len", WR_LEN, e.len);
      chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
      chk("pipe_reset_cycles", 32'(pr_cnt), 32'(e.pr));
      chk("rd_start_pulses", 32'(rds), 32'(e.st));
      chk("wr_start_pulses", 32'(wrs), 32'(e.st));
    end
  endtask

  task automatic issue(input logic [31:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] len, input int rd_off, input int wr_off);
    for (int i = 0; i < 10 && CONFIG_READY !== 1'b1; i++) step();
    chk("ready_before_issue", {31'd0, CONFIG_READY}, 32'd1);
    CONFIG_DATA  = {len, dst, src, cmd};
    CONFIG_VALID = 1'b1;
    push_exp(cmd, src, dst, len, rd_off, wr_off);
    step();
    CONFIG_VALID = 1'b0;
  endtask

  task automatic complete(input int rd_off, input int wr_off);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (CONFIG_READY === 1'b1) begin
        seen = 1'b1;
        break;
      end
      RD_DONE = (rel >= 0 && rel == rd_off);
      WR_DONE = (rel >= 0 && rel == wr_off);
    end
    RD_DONE = 1'b0;
    WR_DONE = 1'b0;
    chk("return_to_idle", {31'd0, seen}, 32'd1);
    check_result();
  endtask

  initial begin
    ARESETN = 1'b0; CONFIG_VALID = 1'b0; CONFIG_DATA = '0;
    RD_DONE = 1'b0; WR_DONE = 1'b0;
    repeat (3) step();
    chk("rst_ready", {31'd0, CONFIG_READY}, 32'd1);
    chk("rst_pipe_reset", {31'd0, PIPE_RESET}, 32'd0);
    chk("rst_start", {30'd0, RD_START, WR_START}, 32'd0);
    chk("rst_status", {30'd0, STATUS}, 32'd0);
    chk("rst_cycles", CYCLES, 32'd0);
    chk("rst_addr", RD_ADDR | WR_ADDR | RD_LEN | WR_LEN, 32'd0);
    ARESETN = 1'b1;
    repeat (4) step();

    issue(32'd1, 32'h1000, 32'h2000, 32'h100, 11, 21);   // RD at RUN+10, WR at RUN+20
    complete(11, 21);
    issue(32'd1, 32'h3000, 32'h4000, 32'h40, 0, 0);      // both in START
    complete(0, 0);
    issue(32'd3, 32'h5000, 32'h6000, 32'h80, 0, 5);      // RD in START, WR later
    complete(0, 5);
    issue(32'd0, 32'h7000, 32'h7100, 32'h10, -1, -1);    // cmd bit 0 clear
    complete(-1, -1);
    issue(32'd1, 32'h7200, 32'h7300, 32'h0, -1, -1);     // zero length
    complete(-1, -1);
    issue(32'd1, 32'h8000, 32'h9000, 32'h20, 11, -1);    // WR never done
    complete(11, -1);
    issue(32'd1, 32'hA000, 32'hB000, 32'h30, 3, 2);      // normal after timeout
    complete(3, 2);

    // Back-to-back: VALID stays high across FIN, data changes while busy
    CONFIG_DATA  = {32'h10, 32'hC100, 32'hC000, 32'd0};
    CONFIG_VALID = 1'b1;
    push_exp(32'd0, 32'hC000, 32'hC100, 32'h10, -1, -1);
    step();
    CONFIG_DATA = {32'h44, 32'hD100, 32'hD000, 32'd1};
    push_exp(32'd1, 32'hD000, 32'hD100, 32'h44, 2, 3);
    step();
    idle_cyc = cyc;
    check_result();
    step();
    CONFIG_VALID = 1'b0;
    chk("b2b_first_idle_accept", 32'(acc_cyc), 32'(idle_cyc));
    chk("b2b_new_addr", RD_ADDR, 32'hD000);
    complete(2, 3);

    // Reset in the middle of RUN
    issue(32'd1, 32'hE000, 32'hF000, 32'h50, 30, 40);
    for (int i = 0; i < 50 && rel != 3; i++) step();
    ARESETN = 1'b0;
    #1;
    chk("abort_ready", {31'd0, CONFIG_READY}, 32'd1);
    chk("abort_status", {30'd0, STATUS}, 32'd0);
    chk("abort_cycles", CYCLES, 32'd0);
    chk("abort_addr", RD_ADDR | WR_ADDR | RD_LEN | WR_LEN, 32'd0);
    chk("abort_pipe_reset", {31'd0, PIPE_RESET}, 32'd0);
    sb.delete();
    last_cyc = 32'd0;
    repeat (2) step();
    ARESETN = 1'b1;
    rds = 0; wrs = 0; pr_cnt = 0;
    RD_DONE = 1'b1;
    step();
    RD_DONE = 1'b0;
    repeat (4) step();
    chk("post_abort_no_start", 32'(rds + wrs), 32'd0);
    chk("post_abort_no_flush", 32'(pr_cnt), 32'd0);
    chk("post_abort_ready", {31'd0, CONFIG_READY}, 32'd1);
    chk("post_abort_status", {30'd0, STATUS}, 32'd0);
    issue(32'd1, 32'h1234, 32'h5678, 32'h8, 4, 4);
    complete(4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameters: NREG, default 4, number of config words; W, default 32, config word width; FLUSH_CYC, default 4, cycles PIPE_RESET is held; TIMEOUT, default 2^24, maximum RUN cycles.
REQ-002 SHALL have port ACLK, input, 1, the only clock.
REQ-003 SHALL have port ARESETN, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port CONFIG_VALID, input, 1, command pending from the config register block.
REQ-005 SHALL have port CONFIG_READY, output, 1, sequencer idle and accepting a command.
REQ-006 SHALL have port CONFIG_DATA, input, NREG*W, with word0 = cmd, word1 = src, word2 = dst, word3 = len in bytes.
REQ-007 SHALL have ports RD_START, output, 1, one-cycle pulse; RD_ADDR, output, 32; RD_LEN, output, 32; RD_DONE, input, 1, one-cycle pulse.
REQ-008 SHALL have ports WR_START, output, 1; WR_ADDR, output, 32; WR_LEN, output, 32; WR_DONE, input, 1; these mirror the RD_* ports.
REQ-009 SHALL have port PIPE_RESET, output, 1, active-high flush of the datapath.
REQ-010 SHALL have ports STATUS, output, 2 (00 OK, 01 BADCMD, 10 TIMEOUT); and CYCLES, output, 32, RUN duration of the last command.

Function
REQ-011 SHALL use the states IDLE, FLUSH, START, RUN and FIN.
REQ-012 SHALL assert CONFIG_READY only in IDLE; a command is accepted when CONFIG_VALID && CONFIG_READY.
REQ-013 SHALL, on acceptance, register src, dst and len into RD_ADDR/WR_ADDR and RD_LEN/WR_LEN, which then hold until the next acceptance.
REQ-014 SHALL, on acceptance: if cmd[0]==0 or len==0, set STATUS=BADCMD and enter FIN; otherwise load the flush counter with FLUSH_CYC and enter FLUSH.
REQ-015 SHALL assert PIPE_RESET throughout FLUSH, which lasts exactly FLUSH_CYC cycles, then enter START.
REQ-016 SHALL pulse RD_START and WR_START together for the single START cycle, clear the done flags and CYCLES, then enter RUN.
REQ-017 SHALL record RD_DONE and WR_DONE as sticky flags in START and in RUN; both may arrive in the same cycle, and either may arrive in the START cycle.
REQ-018 SHALL increment CYCLES by 1 each RUN cycle, saturating at all-ones.
REQ-019 SHALL leave RUN for FIN with STATUS=OK in the cycle both flags are set, including when they are set by pulses arriving that same cycle.
REQ-020 SHALL leave RUN for FIN with STATUS=TIMEOUT when CYCLES reaches TIMEOUT with either flag still clear, and SHALL assert PIPE_RESET in FIN for that case.
REQ-021 SHALL spend exactly one cycle in FIN and then return to IDLE, so CONFIG_READY rises one cycle after FIN.
REQ-022 SHALL ignore RD_DONE and WR_DONE in IDLE, FLUSH and FIN.
REQ-023 SHALL hold STATUS and CYCLES stable from FIN until the next acceptance.
REQ-024 SHALL ignore changes on CONFIG_DATA while not in IDLE.

Reset
REQ-025 SHALL, while ARESETN is low, asynchronously force the state to IDLE and drive CONFIG_READY=1, RD_START=WR_START=0, PIPE_RESET=0, STATUS=00, CYCLES=0, all addresses and lengths to 0, and both flags clear.
REQ-026 SHALL treat reset asserted mid-run as an abort: no START pulse is issued after reset, and the first post-reset command is accepted normally.
REQ-027 SHALL release reset synchronously to ACLK via the codebase's standard reset synchronizer; the deassertion edge is metastability-safe.

Structure
REQ-028 SHALL take the state encoding, the STATUS codes and the CONFIG_DATA word indices from a shared package, conf_pkg, which the config register block also uses.
REQ-029 SHALL contain one sub-module, done_tracker, holding the two sticky flags and the saturating cycle counter; all other logic is flat.

Verification
REQ-030 Normal run: cmd=1, src=0x1000, dst=0x2000, len=0x100; RD_DONE at RUN+10, WR_DONE at RUN+20 -> exactly 4 PIPE_RESET cycles, single start pulses, STATUS=00, CYCLES=21, CONFIG_READY high 2 cycles after WR_DONE.
REQ-031 Simultaneous done: RD_DONE and WR_DONE pulse in the START cycle -> FIN next cycle, STATUS=00, CYCLES=0.
REQ-032 Bad command: cmd=0, or cmd=1 with len=0 -> no PIPE_RESET, no start pulses, STATUS=01, CONFIG_READY back after 2 cycles.
REQ-033 Timeout with TIMEOUT=64: RD_DONE only -> STATUS=10 at CYCLES=64, PIPE_RESET high in FIN, next command accepted normally.
REQ-034 Reset mid-RUN: drop ARESETN -> outputs take reset values immediately; a late RD_DONE after reset is ignored.
REQ-035 Back-to-back: CONFIG_VALID held high across FIN -> second command accepted in its first IDLE cycle with the new addresses.
